// File: rtl/supply_pkg.sv
// Shared types, widths, constants and saturating arithmetic helpers for the
// red-box supply manager and its per-player counter slices.
package supply_pkg;

    localparam int unsigned NUM_BOX    = 10;
    localparam int unsigned NUM_PLAYER = 2;
    localparam int unsigned COORD_W    = 10;
    localparam int unsigned AMMO_W     = 8;
    localparam int unsigned HEALTH_W   = 7;
    localparam int unsigned FLASH_W    = 5;
    localparam int unsigned SQ_W       = 21;
    localparam int unsigned DIST_W     = 22;
    localparam int unsigned IDX_W      = 4;

    localparam logic [7:0] AMMO_MAX      = 8'd99;
    localparam logic [7:0] AMMO_REFILL   = 8'd20;
    localparam logic [7:0] AMMO_INIT     = 8'd50;
    localparam logic [6:0] HEALTH_MAX    = 7'd100;
    localparam logic [6:0] HEALTH_REFILL = 7'd25;
    localparam logic [6:0] HIT_DAMAGE    = 7'd10;
    localparam logic [4:0] FLASH_FRAMES  = 5'd30;

    // Refill outweighs damage, so a simultaneous pickup and hit is a net gain.
    localparam logic [6:0] HEALTH_NET_GAIN = HEALTH_REFILL - HIT_DAMAGE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ATTRIB = 2'd1,
        APPLY  = 2'd2
    } state_t;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] lim);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, lim}) begin
            return lim;
        end else begin
            return sum[7:0];
        end
    endfunction

    function automatic logic [6:0] sat_add7(input logic [6:0] a, input logic [6:0] b,
                                            input logic [6:0] lim);
        logic [7:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, lim}) begin
            return lim;
        end else begin
            return sum[6:0];
        end
    endfunction

    function automatic logic [6:0] sat_sub7(input logic [6:0] a, input logic [6:0] b);
        if (a > b) begin
            return a - b;
        end else begin
            return 7'd0;
        end
    endfunction

    function automatic logic signed [10:0] coord_diff(input logic [9:0] a, input logic [9:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    function automatic logic [20:0] square11(input logic signed [10:0] v);
        logic [10:0] mag;
        logic [20:0] wide;
        if (v[10]) begin
            mag = ~$unsigned(v) + 11'd1;
        end else begin
            mag = $unsigned(v);
        end
        wide = {10'd0, mag};
        return wide * wide;
    endfunction

endpackage

// File: rtl/supply_player_ctr.sv
// One player's ammo/health/death/flash state, driven by refill, fire, hit and
// frame-tick strobes from the supply manager top level.
module supply_player_ctr
    import supply_pkg::*;
(
    input  logic       clk,
    input  logic       start,
    input  logic       refill,
    input  logic       fire,
    input  logic       hit,
    input  logic       frame_tick,
    output logic [7:0] ammo,
    output logic [6:0] health,
    output logic       fire_grant,
    output logic       dead,
    output logic       flash
);

    logic [7:0] ammo_r;
    logic [7:0] ammo_nxt_s;
    logic [6:0] health_r;
    logic [6:0] health_nxt_s;
    logic       dead_r;
    logic       dead_nxt_s;
    logic       grant_r;
    logic       flash_r;
    logic [4:0] flash_cnt_r;
    logic [4:0] flash_cnt_nxt_s;
    logic       fire_ok_s;
    logic       hit_ok_s;
    logic       refill_ok_s;

    // Next-state arithmetic; a dead player is frozen except for its health floor.
    always_comb begin
        fire_ok_s   = fire & (ammo_r != 8'd0) & ~dead_r;
        hit_ok_s    = hit & ~dead_r;
        refill_ok_s = refill & ~dead_r;

        if (refill_ok_s && fire_ok_s) begin
            ammo_nxt_s = sat_add8(ammo_r - 8'd1, AMMO_REFILL, AMMO_MAX);
        end else if (refill_ok_s) begin
            ammo_nxt_s = sat_add8(ammo_r, AMMO_REFILL, AMMO_MAX);
        end else if (fire_ok_s) begin
            ammo_nxt_s = ammo_r - 8'd1;
        end else begin
            ammo_nxt_s = ammo_r;
        end

        if (refill_ok_s && hit_ok_s) begin
            health_nxt_s = sat_add7(health_r, HEALTH_NET_GAIN, HEALTH_MAX);
        end else if (refill_ok_s) begin
            health_nxt_s = sat_add7(health_r, HEALTH_REFILL, HEALTH_MAX);
        end else if (hit_ok_s) begin
            health_nxt_s = sat_sub7(health_r, HIT_DAMAGE);
        end else begin
            health_nxt_s = health_r;
        end

        dead_nxt_s = dead_r | (hit_ok_s & (health_nxt_s == 7'd0));

        if (refill_ok_s) begin
            flash_cnt_nxt_s = FLASH_FRAMES;
        end else if (frame_tick && (flash_cnt_r != 5'd0)) begin
            flash_cnt_nxt_s = flash_cnt_r - 5'd1;
        end else begin
            flash_cnt_nxt_s = flash_cnt_r;
        end
    end

    // Player state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!start) begin
            ammo_r      <= AMMO_INIT;
            health_r    <= HEALTH_MAX;
            dead_r      <= 1'b0;
            grant_r     <= 1'b0;
            flash_cnt_r <= 5'd0;
            flash_r     <= 1'b0;
        end else begin
            ammo_r      <= ammo_nxt_s;
            health_r    <= health_nxt_s;
            dead_r      <= dead_nxt_s;
            grant_r     <= fire_ok_s;
            flash_cnt_r <= flash_cnt_nxt_s;
            flash_r     <= (flash_cnt_nxt_s != 5'd0);
        end
    end

    assign ammo       = ammo_r;
    assign health     = health_r;
    assign dead       = dead_r;
    assign fire_grant = grant_r;
    assign flash      = flash_r;

endmodule

// File: rtl/supply_manager.sv
// Turns red-box pickup edges into ammo/health refills for the nearer living
// player, one pickup every three cycles, and hosts the two player counters.
module supply_manager
    import supply_pkg::*;
(
    input  logic       Clk,
    input  logic       Start,
    input  logic       frame_clk,
    input  logic [9:0] Replenish,
    input  logic [9:0] RedBox_X [10],
    input  logic [9:0] RedBox_Y [10],
    input  logic [9:0] Player_X [2],
    input  logic [9:0] Player_Y [2],
    input  logic [1:0] Fire,
    input  logic [1:0] Hit,
    output logic [7:0] Ammo [2],
    output logic [6:0] Health [2],
    output logic [1:0] Fire_Grant,
    output logic [1:0] Dead,
    output logic [1:0] Flash
);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [9:0]  repl_d_r;
    logic        armed_r;
    logic [9:0]  pending_r;
    logic [9:0]  pending_nxt_s;
    logic [9:0]  rise_s;
    logic [9:0]  clr_mask_s;
    logic        frame_d_r;
    logic        frame_tick_r;
    logic [3:0]  idx_r;
    logic [3:0]  first_idx_s;
    logic        any_s;
    logic        latch_s;
    logic        attrib_s;
    logic        apply_s;
    logic [21:0] d0_r;
    logic [21:0] d1_r;
    logic [21:0] dist_s [2];
    logic signed [10:0] dx_s [2];
    logic signed [10:0] dy_s [2];
    logic [1:0]  refill_s;

    // armed_r masks the first cycle after reset so a level held through reset is not an edge.
    always_comb begin
        rise_s = Replenish & ~repl_d_r & {10{armed_r}};
        any_s  = |pending_r;
        first_idx_s = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (pending_r[i]) begin
                first_idx_s = 4'(i);
            end else begin
                first_idx_s = first_idx_s;
            end
        end
        if (latch_s) begin
            clr_mask_s = 10'd1 << first_idx_s;
        end else begin
            clr_mask_s = 10'd0;
        end
        pending_nxt_s = (pending_r & ~clr_mask_s) | rise_s;
    end

    // Next-state and strobes for the IDLE -> ATTRIB -> APPLY pickup pipeline.
    always_comb begin
        state_nxt_s = state_r;
        latch_s     = 1'b0;
        attrib_s    = 1'b0;
        apply_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    state_nxt_s = ATTRIB;
                    latch_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ATTRIB: begin
                state_nxt_s = APPLY;
                attrib_s    = 1'b1;
            end
            APPLY: begin
                state_nxt_s = IDLE;
                apply_s     = 1'b1;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Squared Euclidean distance from each player to the latched box.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            dx_s[p]   = coord_diff(Player_X[p], RedBox_X[idx_r]);
            dy_s[p]   = coord_diff(Player_Y[p], RedBox_Y[idx_r]);
            dist_s[p] = {1'b0, square11(dx_s[p])} + {1'b0, square11(dy_s[p])};
        end
    end

    // Winner selection: dead players are skipped, ties favour player 0.
    always_comb begin
        refill_s = 2'b00;
        if (apply_s) begin
            if (Dead[0] && Dead[1]) begin
                refill_s = 2'b00;
            end else if (Dead[0]) begin
                refill_s = 2'b10;
            end else if (Dead[1]) begin
                refill_s = 2'b01;
            end else if (d0_r <= d1_r) begin
                refill_s = 2'b01;
            end else begin
                refill_s = 2'b10;
            end
        end else begin
            refill_s = 2'b00;
        end
    end

    // Edge detectors, pending mask, FSM state and attribution registers.
    always_ff @(posedge Clk) begin
        if (!Start) begin
            repl_d_r     <= 10'd0;
            armed_r      <= 1'b0;
            pending_r    <= 10'd0;
            frame_d_r    <= 1'b0;
            frame_tick_r <= 1'b0;
            state_r      <= IDLE;
            idx_r        <= 4'd0;
            d0_r         <= 22'd0;
            d1_r         <= 22'd0;
        end else begin
            repl_d_r     <= Replenish;
            armed_r      <= 1'b1;
            pending_r    <= pending_nxt_s;
            frame_d_r    <= frame_clk;
            frame_tick_r <= frame_clk & ~frame_d_r;
            state_r      <= state_nxt_s;
            if (latch_s) begin
                idx_r <= first_idx_s;
            end
            if (attrib_s) begin
                d0_r <= dist_s[0];
                d1_r <= dist_s[1];
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_player
        supply_player_ctr u_ctr (
            .clk        (Clk),
            .start      (Start),
            .refill     (refill_s[p]),
            .fire       (Fire[p]),
            .hit        (Hit[p]),
            .frame_tick (frame_tick_r),
            .ammo       (Ammo[p]),
            .health     (Health[p]),
            .fire_grant (Fire_Grant[p]),
            .dead       (Dead[p]),
            .flash      (Flash[p])
        );
    end

endmodule

// File: doc/supply_manager.md
# supply_manager

Consumes red-box pickup pulses and converts them into per-player ammo and health. It sits directly downstream of the red-box block, reading its `Replenish`, `RedBox_X` and `RedBox_Y` outputs together with live player positions. It also owns each player's saturating ammo and health counters, fire gating, death flag and pickup flash timer. Outputs feed the shooting logic, the HUD and the sprite renderer.

## Interface
- `AMMO_MAX`, 99: ammo saturation ceiling.
- `AMMO_REFILL`, 20: ammo added per pickup.
- `HEALTH_MAX`, 100: health ceiling and reset value.
- `HEALTH_REFILL`, 25: health added per pickup.
- `HIT_DAMAGE`, 10: health removed per hit pulse.
- `FLASH_FRAMES`, 30: frame ticks of pickup flash.
- `AMMO_INIT`, 50: ammo reset value.

Ports:
- `Clk`  in  1: system clock; the only clock.
- `Start`  in  1: synchronous active-low reset (low = reset).
- `frame_clk`  in  1: vertical-sync-rate tick, sampled in `Clk`.
- `Replenish`  in  10: per-box pickup flags from the red-box block.
- `RedBox_X`, `RedBox_Y`  in  10 ×[10]: box coordinates, held after pickup.
- `Player_X`, `Player_Y`  in  10 ×[2]: player positions.
- `Fire`  in  1 ×[2]: shot request, one-cycle pulse.
- `Hit`  in  1 ×[2]: damage event, one-cycle pulse.
- `Ammo`  out  8 ×[2]: current ammo.
- `Health`  out  7 ×[2]: current health.
- `Fire_Grant`  out  1 ×[2]: one-cycle shot permission.
- `Dead`  out  1 ×[2]: sticky death flag.
- `Flash`  out  1 ×[2]: pickup flash active.

## Operation
- Reset values:
  - `Ammo` = AMMO_INIT; `Health` = HEALTH_MAX.
  - `Fire_Grant`, `Dead`, `Flash` = 0.
  - Pending mask = 0; FSM in IDLE.
  - Edge registers for `Replenish` and `frame_clk` = 0.
- Edge capture:
  - A rising edge on `Replenish[i]` sets `pending[i]`.
  - If a set and a clear of the same bit coincide, the set wins.
- FSM:
  - IDLE: when the pending mask is nonzero, latch the lowest set index `k`, clear `pending[k]`, go to ATTRIB.
  - ATTRIB: register `d[p] = (Player_X[p]-RedBox_X[k])² + (Player_Y[p]-RedBox_Y[k])²` for p = 0, 1. Differences are 11-bit signed, squares 21-bit, the sum 22-bit unsigned. Go to APPLY.
  - APPLY: the winner is the player with smaller `d`; a tie goes to player 0.
    - A dead player never wins; if one player is dead, the other wins.
    - If both are dead, the pickup is discarded.
    - Winner gets `Ammo` = min(Ammo+AMMO_REFILL, AMMO_MAX) and `Health` = min(Health+HEALTH_REFILL, HEALTH_MAX).
    - Winner's flash counter loads FLASH_FRAMES. Go to IDLE.
- Fire:
  - `Fire[p]` with `Ammo[p]`>0 and `!Dead[p]` produces `Fire_Grant[p]` the next cycle and decrements ammo.
  - Otherwise there is no grant.
- Hit:
  - `Hit[p]` with `!Dead[p]` sets `Health` = max(Health−HIT_DAMAGE, 0).
  - Reaching 0 sets `Dead[p]`, which holds until reset.
  - Once dead, `Ammo` freezes.
- Same-cycle events on one player:
  - APPLY plus Fire: net = sat(Ammo−1+REFILL); the grant is still issued.
  - APPLY plus Hit: net = clamp(Health+REFILL−DAMAGE); death is judged on the net value.
- Flash counter: decrements on each `frame_clk` rising edge while nonzero. `Flash[p]` = (counter ≠ 0).

## Timing
- `Replenish[i]` rises in cycle N:
  - `pending[i]` is set at N+1.
  - IDLE latches the index at N+1, ATTRIB runs at N+2, APPLY at N+3.
  - Counters show the new values at N+4.
- Throughput: one pickup per 3 cycles. Ten simultaneous edges drain in index order within 30 cycles.
- Fire/Hit latency: 1 cycle. Back-to-back pulses every cycle are each honoured.
- `frame_clk` edge detection: 1-cycle delay register plus an edge register, i.e. 2-cycle latency.
- `Start` low mid-operation: all state returns to reset values on the next edge. An in-flight pickup is lost; pending edges are lost.
- A `Replenish` already high when `Start` rises is not an edge (the delay register resets to 0 but is sampled after release). The first rising edge after release counts.

## Structure
- Package `supply_pkg`:
  - State enum {IDLE, ATTRIB, APPLY}.
  - Counter widths and default constants.
  - Saturating add/sub functions.
- Sub-module `supply_player_ctr`, instantiated ×2. It holds the Ammo/Health/Dead/flash counter for one player and takes refill, fire, hit and frame-tick strobes.
- Top level holds edge capture, the pending mask, the priority encoder, distance registers and the FSM.

## Test plan
- **Single pickup to the nearer player.** Stimulus: box 3 at (100,100); P0 at (104,100), P1 at (300,300); `Replenish[3]` pulse. Response: P0 Ammo 50→70 and Health stays 100 at N+4; P0 `Flash` high for 30 frame ticks.
- **Ammo saturation and tie.** Stimulus: both players equidistant from box 0; P0 Ammo=90; pickup. Response: P0 Ammo=99; P1 unchanged.
- **Burst drain.** Stimulus: `Replenish[9:0]` all rise in the same cycle. Response: ten APPLYs, indices 0→9, the last committed by N+31.
- **Fire gating.** Stimulus: P1 Ammo=1; `Fire[1]` on two consecutive cycles. Response: one `Fire_Grant`, Ammo=0, second request denied.
- **Death.** Stimulus: P0 Health=10; `Hit[0]`. Response: Health=0, `Dead[0]`=1. A following pickup near P0 goes to P1; `Fire[0]` gets no grant.
- **Reset mid-burst.** Stimulus: `Start` low during ATTRIB. Response: Ammo=50, Health=100, mask 0, no late APPLY.
